// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding request, split read/write bus channels,
// misalignment/illegal-funct3 detection and sub-word lane handling.
module load_store_unit #(
  parameter int WORD_ADDR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_req_write,
  input  logic [2:0]  lsu_req_funct3,
  input  logic [31:0] lsu_req_addr,
  input  logic [31:0] lsu_req_wdata,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rsp_rdata,
  output logic        lsu_rsp_error,
  output logic        d_raddr_valid,
  input  logic        d_raddr_ready,
  output logic [31:0] d_raddr,
  input  logic        d_rdata_valid,
  output logic        d_rdata_ready,
  input  logic [31:0] d_rdata,
  output logic        d_waddr_valid,
  input  logic        d_waddr_ready,
  output logic [31:0] d_waddr,
  output logic        d_wdata_valid,
  input  logic        d_wdata_ready,
  output logic [31:0] d_wdata,
  output logic [3:0]  d_wstrb
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, RESP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic        waddr_pend_reg, wdata_pend_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_error_reg;

  logic        accept, req_error, store_ok;
  logic        waddr_done, wdata_done;
  logic [31:0] store_data, load_value, bus_addr;
  logic [3:0]  store_strb;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign accept   = (state_reg == IDLE) && lsu_req_valid;
  assign store_ok = lsu_req_write && !req_error;

  // Illegal funct3 for the direction, or natural-alignment violation.
  always_comb begin
    req_error = 1'b0;
    if (lsu_req_write)
      req_error = lsu_req_funct3[2] || (lsu_req_funct3[1:0] == 2'b11);
    else
      req_error = (lsu_req_funct3[1:0] == 2'b11) || (lsu_req_funct3[2:1] == 2'b11);
    if ((lsu_req_funct3[1:0] == 2'b01) && lsu_req_addr[0])
      req_error = 1'b1;
    if ((lsu_req_funct3[1:0] == 2'b10) && (lsu_req_addr[1:0] != 2'b00))
      req_error = 1'b1;
  end

  // Sub-word stores replicate the data across all lanes; the strobe selects one.
  always_comb begin
    store_data = lsu_req_wdata;
    store_strb = 4'b1111;
    case (lsu_req_funct3[1:0])
      2'b00: begin
        store_data = {4{lsu_req_wdata[7:0]}};
        store_strb = 4'b0001 << lsu_req_addr[1:0];
      end
      2'b01: begin
        store_data = {2{lsu_req_wdata[15:0]}};
        store_strb = 4'b0011 << {lsu_req_addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_byte  = d_rdata[{addr_reg[1:0], 3'b000} +: 8];
    load_half  = d_rdata[{addr_reg[1], 4'b0000} +: 16];
    load_value = d_rdata;
    case (funct3_reg)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b100:  load_value = {24'h0, load_byte};
      3'b101:  load_value = {16'h0, load_half};
      default: load_value = d_rdata;
    endcase
  end

  assign waddr_done = !waddr_pend_reg || d_waddr_ready;
  assign wdata_done = !wdata_pend_reg || d_wdata_ready;

  always_comb begin
    state_next    = state_reg;
    lsu_req_ready = 1'b0;
    d_raddr_valid = 1'b0;
    d_rdata_ready = 1'b0;
    lsu_rsp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        lsu_req_ready = 1'b1;
        if (lsu_req_valid) begin
          if (req_error)          state_next = RESP;
          else if (lsu_req_write) state_next = WRITE;
          else                    state_next = RADDR;
        end
      end
      RADDR: begin
        d_raddr_valid = 1'b1;
        if (d_raddr_ready) state_next = RDATA;
      end
      RDATA: begin
        d_rdata_ready = 1'b1;
        if (d_rdata_valid) state_next = RESP;
      end
      WRITE: begin
        if (waddr_done && wdata_done) state_next = RESP;
      end
      RESP: begin
        lsu_rsp_valid = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      addr_reg       <= 32'h0;
      funct3_reg     <= 3'b000;
      wdata_reg      <= 32'h0;
      wstrb_reg      <= 4'b0000;
      waddr_pend_reg <= 1'b0;
      wdata_pend_reg <= 1'b0;
      rsp_rdata_reg  <= 32'h0;
      rsp_error_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg       <= lsu_req_addr;
        funct3_reg     <= lsu_req_funct3;
        wdata_reg      <= store_data;
        wstrb_reg      <= store_ok ? store_strb : 4'b0000;
        waddr_pend_reg <= store_ok;
        wdata_pend_reg <= store_ok;
      end
      if (state_reg == WRITE) begin
        if (d_waddr_ready) waddr_pend_reg <= 1'b0;
        if (d_wdata_ready) wdata_pend_reg <= 1'b0;
      end
      // Response fields change only as a new response is entered.
      if (accept && req_error) begin
        rsp_rdata_reg <= 32'h0;
        rsp_error_reg <= 1'b1;
      end
      if ((state_reg == RDATA) && d_rdata_valid) begin
        rsp_rdata_reg <= load_value;
        rsp_error_reg <= 1'b0;
      end
      if ((state_reg == WRITE) && waddr_done && wdata_done) begin
        rsp_rdata_reg <= 32'h0;
        rsp_error_reg <= 1'b0;
      end
    end
  end

  assign bus_addr      = (WORD_ADDR != 0) ? {addr_reg[31:2], 2'b00} : addr_reg;
  assign d_raddr       = bus_addr;
  assign d_waddr       = bus_addr;
  assign d_wdata       = wdata_reg;
  assign d_wstrb       = wstrb_reg;
  assign d_waddr_valid = (state_reg == WRITE) && waddr_pend_reg;
  assign d_wdata_valid = (state_reg == WRITE) && wdata_pend_reg;
  assign lsu_rsp_rdata = rsp_rdata_reg;
  assign lsu_rsp_error = rsp_error_reg;

endmodule
